// File: rtl/picosoc_timer.sv
// picosoc_timer: iomem-mapped 32-bit down-counting timer with 16-bit prescaler and level irq.
// One wait state per access; rdata is zero outside the ready cycle so responders can be OR-combined.
module picosoc_timer #(
    parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        iomem_valid,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic        iomem_ready,
    output logic [31:0] iomem_rdata,
    output logic        irq
);
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic [2:0]  ctrl_q, ctrl_d;
    logic [15:0] presc_q, presc_d;
    logic [15:0] pc_q, pc_d;
    logic [31:0] reload_q, reload_d;
    logic [31:0] count_q, count_d;
    logic        exp_q, exp_d;
    logic        sel, wr, wr_ctrl, w1c, tick, expire;
    logic [5:0]  off;
    logic [31:0] wmask, rmux;
    logic        unused_addr_lsb;

    assign sel     = iomem_valid && iomem_addr[31:8] == BASE_ADDR[31:8];
    assign off     = iomem_addr[7:2];
    assign wr      = ready_q && sel;
    assign wr_ctrl = wr && off == 6'd0 && iomem_wstrb[0];
    assign w1c     = wr && off == 6'd4 && iomem_wstrb[0] && iomem_wdata[0];
    assign wmask   = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}}, {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
    assign tick    = ctrl_q[0] && pc_q == presc_q;
    assign expire  = tick && count_q == 32'd0;
    assign unused_addr_lsb = ^iomem_addr[1:0];

    assign rmux = off == 6'd0 ? {29'd0, ctrl_q} :
                  off == 6'd1 ? {16'd0, presc_q} :
                  off == 6'd2 ? reload_q :
                  off == 6'd3 ? count_q :
                  off == 6'd4 ? {31'd0, exp_q} : 32'd0;

    always_comb begin
        ready_d  = sel && !ready_q;
        rdata_d  = ready_d && iomem_wstrb == 4'd0 ? rmux : 32'd0;
        // the written EN wins over a one-shot expiry clearing it in the same cycle
        ctrl_d   = wr_ctrl ? iomem_wdata[2:0] : {ctrl_q[2:1], ctrl_q[0] && !(expire && !ctrl_q[1])};
        pc_d     = tick || (wr_ctrl && !ctrl_q[0] && iomem_wdata[0]) ? 16'd0 :
                   ctrl_q[0] ? pc_q + 16'd1 : pc_q;
        presc_d  = wr && off == 6'd1 ? (presc_q & ~wmask[15:0]) | (iomem_wdata[15:0] & wmask[15:0]) : presc_q;
        reload_d = wr && off == 6'd2 ? (reload_q & ~wmask) | (iomem_wdata & wmask) : reload_q;
        count_d  = wr && off == 6'd3 ? (count_q & ~wmask) | (iomem_wdata & wmask) :
                   !tick ? count_q :
                   count_q != 32'd0 ? count_q - 32'd1 :
                   ctrl_q[1] ? reload_q : count_q;
        exp_d    = expire || (exp_q && !w1c);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready_q  <= 1'b0;
            rdata_q  <= 32'd0;
            ctrl_q   <= 3'd0;
            presc_q  <= 16'd0;
            pc_q     <= 16'd0;
            reload_q <= 32'd0;
            count_q  <= 32'd0;
            exp_q    <= 1'b0;
        end else begin
            ready_q  <= ready_d;
            rdata_q  <= rdata_d;
            ctrl_q   <= ctrl_d;
            presc_q  <= presc_d;
            pc_q     <= pc_d;
            reload_q <= reload_d;
            count_q  <= count_d;
            exp_q    <= exp_d;
        end
    end

    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign irq         = exp_q && ctrl_q[2];
endmodule

// File: tb/tb_picosoc_timer.sv
// tb_picosoc_timer: directed plus random bus traffic against a cycle-level behavioural timer model.
// Read expectations go to a scoreboard queue; a negedge monitor pops them on each ready pulse.
module tb_picosoc_timer;
    localparam logic [31:0] BASE = 32'h0300_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        valid = 1'b0;
    logic [3:0]  wstrb = 4'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        ready;
    logic [31:0] rdata;
    logic        irq;

    int checks = 0;
    int errors = 0;

    typedef struct {bit chk; logic [31:0] val;} exp_t;
    exp_t sbq[$];

    bit          m_en, m_per, m_ie, m_exp;
    int unsigned m_presc, m_pc, m_reload, m_count;
    bit          prev_ready = 1'b0;

    picosoc_timer #(.BASE_ADDR(BASE)) dut (
        .clk(clk), .resetn(resetn), .iomem_valid(valid), .iomem_wstrb(wstrb),
        .iomem_addr(addr), .iomem_wdata(wdata), .iomem_ready(ready),
        .iomem_rdata(rdata), .irq(irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input int off);
        case (off)
            0:       return {29'd0, m_ie, m_per, m_en};
            4:       return m_presc;
            8:       return m_reload;
            12:      return m_count;
            16:      return {31'd0, m_exp};
            default: return 32'd0;
        endcase
    endfunction

    // One clock edge of the timer as the register-map rules describe it; w marks a committing write.
    task automatic model_edge(input bit w, input int off, input logic [3:0] s, input logic [31:0] d);
        bit          tk, set, was_en;
        int unsigned old_count;
        logic [31:0] m;
        if (!resetn) return;
        tk = m_en && m_pc == m_presc;
        set = tk && m_count == 0;
        was_en = m_en;
        old_count = m_count;
        m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
        if (m_en) m_pc = tk ? 0 : (m_pc + 1) % 65536;
        if (tk) begin
            if (m_count > 0) m_count = m_count - 1;
            else if (m_per) m_count = m_reload;
            else m_en = 1'b0;
        end
        if (w) begin
            case (off)
                0: if (s[0]) begin
                    m_en = d[0]; m_per = d[1]; m_ie = d[2];
                    if (!was_en && d[0]) m_pc = 0;
                end
                4:  m_presc = ((m_presc & ~m) | (d & m)) & 32'h0000_FFFF;
                8:  m_reload = (m_reload & ~m) | (d & m);
                12: m_count = (old_count & ~m) | (d & m);
                16: if (s[0] && d[0]) m_exp = 1'b0;
                default: ;
            endcase
        end
        if (set) m_exp = 1'b1;
    endtask

    task automatic step(input bit w, input int off, input logic [3:0] s, input logic [31:0] d);
        @(posedge clk);
        model_edge(w, off, s, d);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 4'd0, 32'd0);
    endtask

    task automatic xact(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d,
                        input bit use_k, input logic [31:0] k);
        bit hit;
        int off;
        hit = a[31:8] == BASE[31:8];
        off = int'(a[7:2]) * 4;
        valid = 1'b1; addr = a; wstrb = s; wdata = d;
        if (hit) sbq.push_back('{s == 4'd0, use_k ? k : model_read(off)});
        step(0, 0, 4'd0, 32'd0);
        step(hit && s != 4'd0, off, s, d);
        valid = 1'b0; wstrb = 4'd0;
        chk("handshake_done", sbq.size(), 0);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] k);
        xact(a, 4'd0, 32'd0, 1'b1, k);
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
        xact(a, s, d, 1'b0, 32'd0);
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            chk("irq", irq, m_exp && m_ie);
            chk("ready_b2b", prev_ready && ready, 0);
            if (ready) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_ready: ready=1 with no transaction pending, required 0 at %0t", $time);
                end else begin
                    exp_t e;
                    e = sbq.pop_front();
                    if (e.chk) chk("rdata", rdata, e.val);
                end
            end else begin
                chk("rdata_idle", rdata, 0);
            end
            prev_ready = ready;
        end else begin
            prev_ready = 1'b0;
        end
    end

    initial begin
        int n;
        logic [31:0] a, d;
        logic [3:0]  s;
        int kind;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;

        for (int o = 0; o <= 16; o += 4) rd(BASE + o, 32'd0);
        wr(BASE + 8, 4'hF, 32'hDEADBEEF);
        rd(BASE + 8, 32'hDEADBEEF);
        wr(BASE + 8, 4'h1, 32'h0000_00AA);
        rd(BASE + 8, 32'hDEADBEAA);

        wr(BASE + 4, 4'hF, 32'd0);
        wr(BASE + 8, 4'hF, 32'd3);
        wr(BASE + 12, 4'hF, 32'd3);
        wr(BASE + 0, 4'hF, 32'd7);
        n = 0;
        while (!irq && n < 20) begin idle(1); n++; end
        chk("periodic_first_irq", irq, 1);
        wr(BASE + 16, 4'h1, 32'd1);
        chk("irq_cleared", irq, 0);
        n = 0;
        while (!irq && n < 20) begin idle(1); n++; end
        chk("periodic_reexpire_gap", n, 2);

        n = 0;
        while (m_count != 1 && n < 20) begin idle(1); n++; end
        wr(BASE + 16, 4'h1, 32'd1);
        rd(BASE + 16, 32'd1);
        chk("w1c_collision_irq", irq, 1);
        wr(BASE + 12, 4'hF, 32'h10);
        rd(BASE + 12, 32'h10);

        wr(BASE + 0, 4'hF, 32'd0);
        wr(BASE + 16, 4'h1, 32'd1);
        rd(BASE + 16, 32'd0);
        wr(BASE + 4, 4'hF, 32'd4);
        wr(BASE + 12, 4'hF, 32'd2);
        wr(BASE + 0, 4'hF, 32'd5);
        idle(14);
        chk("oneshot_before", irq, 0);
        idle(1);
        chk("oneshot_expire", irq, 1);
        rd(BASE + 0, 32'd4);
        rd(BASE + 12, 32'd0);
        wr(BASE + 16, 4'h1, 32'd1);
        idle(30);
        rd(BASE + 16, 32'd0);
        chk("oneshot_no_rearm", irq, 0);

        rd(BASE + 32'h100, 32'd0);
        wr(BASE + 32'h100, 4'hF, 32'hFFFF_FFFF);
        rd(BASE + 0, 32'd4);
        rd(BASE + 32'h20, 32'd0);
        wr(BASE + 32'h20, 4'hF, 32'hFFFF_FFFF);
        rd(BASE + 32'h20, 32'd0);
        rd(BASE + 4, 32'd4);
        rd(BASE + 8, 32'd3);

        for (int i = 0; i < 300; i++) begin
            kind = $urandom_range(0, 9);
            a = BASE + 4 * $urandom_range(0, 5);
            if (kind == 9) a = BASE + 32'h100 + 4 * $urandom_range(0, 4);
            if (kind == 8) a = BASE + 32'h20 + 4 * $urandom_range(0, 8);
            s = $urandom_range(0, 1) ? 4'd0 : 4'($urandom_range(1, 15));
            d = $urandom_range(0, 12);
            if (a[7:0] == 8'd0 || $urandom_range(0, 15) == 0) d = $urandom;
            xact(a, s, d, 1'b0, 32'd0);
            idle($urandom_range(0, 3));
        end

        wr(BASE + 4, 4'hF, 32'd0);
        wr(BASE + 8, 4'hF, 32'd2);
        wr(BASE + 12, 4'hF, 32'd2);
        wr(BASE + 0, 4'hF, 32'd7);
        idle(5);
        chk("irq_before_reset", irq, 1);
        valid = 1'b1; addr = BASE + 12; wstrb = 4'd0;
        step(0, 0, 4'd0, 32'd0);
        chk("ready_pending", ready, 1);
        #1 resetn = 1'b0;
        #1;
        chk("reset_ready", ready, 0);
        chk("reset_rdata", rdata, 0);
        chk("reset_irq", irq, 0);
        m_en = 0; m_per = 0; m_ie = 0; m_exp = 0;
        m_presc = 0; m_pc = 0; m_reload = 0; m_count = 0;
        sbq.delete();
        idle(2);
        resetn = 1'b1;
        sbq.push_back('{1'b1, 32'd0});
        idle(2);
        valid = 1'b0;
        chk("post_reset_handshake", sbq.size(), 0);
        idle(10);
        rd(BASE + 12, 32'd0);
        rd(BASE + 0, 32'd0);
        chk("post_reset_irq", irq, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/picosoc_timer.md
# picosoc_timer

Memory-mapped 32-bit down-counting timer that acts as a responder on the SoC's exported `iomem` bus. It decodes its own address window, answers CPU loads and stores with a one-wait-state valid/ready handshake, and drives a level interrupt intended for one of the SoC's external `irq_5..irq_7` inputs. Its `rdata` is zero whenever it is not responding, so several `iomem` responders can be OR-combined at the top level.

## Interface
- `BASE_ADDR`, default 32'h0300_0000: window base. The block is selected when `iomem_addr[31:8] == BASE_ADDR[31:8]`.
- `clk`  in  1  system clock; the block has one clock.
- `resetn`  in  1  reset, asynchronous, active-low.
- `iomem_valid`  in  1  transaction request; held until `iomem_ready`.
- `iomem_wstrb`  in  4  byte write strobes; 0 = read.
- `iomem_addr`  in  32  byte address; `[7:2]` is the register offset, `[1:0]` is ignored.
- `iomem_wdata`  in  32  write data.
- `iomem_ready`  out  1  one-cycle completion pulse.
- `iomem_rdata`  out  32  read data; valid only while `iomem_ready`=1, otherwise 0.
- `irq`  out  1  level interrupt: `STATUS.EXP & CTRL.IE`.

## Operation
- **Register map** (byte offsets):
  - 0x00 CTRL: bit0 EN, bit1 PER (periodic), bit2 IE; other bits read 0.
  - 0x04 PRESCALE: bits [15:0]; other bits read 0.
  - 0x08 RELOAD: 32 bits.
  - 0x0C COUNT: 32 bits. Reads return the live value; writes load it.
  - 0x10 STATUS: bit0 EXP. Write-1-to-clear, using `wdata[0]` under `wstrb[0]`.
  - Other offsets in the window read 0 and ignore writes, but still complete the handshake.
- **Byte strobes:** writes honour `wstrb` per byte lane. Lanes that fall on unimplemented bits are ignored.
- **Handshake:**
  - `sel = iomem_valid & window hit`.
  - Registered rule: `ready <= sel & !ready`.
  - Each transaction produces exactly one `ready` pulse, and a write commits only in the cycle `ready`=1.
  - If `sel` is not asserted, `ready` stays 0 and `rdata` stays 0.
- **Prescaler:** 16-bit counter `pc`, running only while EN=1.
  - `tick = EN & (pc == PRESCALE)`.
  - On `tick`, `pc` returns to 0; otherwise `pc` increments.
  - A CTRL write that changes EN from 0 to 1 clears `pc`.
- **Counter step on `tick`:**
  - If COUNT != 0: COUNT <= COUNT - 1.
  - If COUNT == 0: EXP <= 1. Then, if PER=1, COUNT <= RELOAD; if PER=0, EN <= 0 and COUNT stays 0.
  - Periodic expiry interval: (RELOAD+1)·(PRESCALE+1) cycles.
- **Simultaneous events:**
  - A bus write to COUNT in a tick cycle overrides the counter step.
  - A W1C clear of EXP in the cycle EXP is set: the set wins.
  - A CTRL write in the cycle a one-shot expiry clears EN: the written EN value wins.
  - A PRESCALE write takes effect on the next compare; if the new value is below `pc`, `pc` runs up through 0xFFFF and wraps to 0 before the next tick.
- **Arithmetic:** all counters are unsigned modulo their width. COUNT never wraps below 0.

## Timing
- **Reset values:** `iomem_ready`=0, `iomem_rdata`=0, `irq`=0; all registers, `pc` and EXP are 0.
- **Reset mid-transaction:** `ready` drops immediately. The CPU keeps `valid` asserted, and a fresh transaction starts after reset releases.
- **Read latency:** `valid` rises in cycle N; `ready` and `rdata` are presented in cycle N+1. `rdata` is registered and is 0 in every other cycle.
- **Back-to-back transactions:** minimum spacing is 2 cycles. `ready` is never asserted in two consecutive cycles.
- **Write visibility:** a write committed in cycle N is visible to logic and to readback from cycle N+1.
- **Interrupt timing:** `irq` is registered-derived and rises the cycle after the tick that sets EXP.

## Test plan
- **Reset and readback:** after reset, read every offset → all 0, and each read gives a single `ready` pulse one cycle after `valid`. Then write RELOAD=0xDEADBEEF and read it back → 0xDEADBEEF. Then write 0x000000AA with wstrb=4'b0001 to RELOAD → 0xDEADBEAA.
- **Periodic mode:** PRESCALE=0, RELOAD=3, COUNT=3, CTRL=0x7 (EN, PER, IE) → EXP/`irq` rise every 4 cycles. Clear STATUS with write 0x1 → `irq` drops the next cycle and rises again at the next expiry.
- **One-shot mode:** PRESCALE=4, COUNT=2, CTRL=0x5 (EN, IE) → expiry 15 cycles after enable. EN then reads 0, COUNT holds 0, and no further EXP occurs after it is cleared.
- **Collisions:** W1C on STATUS in the exact expiry cycle → EXP remains 1. Write COUNT=0x10 in a tick cycle → COUNT reads 0x10, not the decremented value.
- **Decode:** access 0x0300_0100 (outside the window) → `ready` never asserts and `rdata`=0. Access offset 0x20 inside the window → `ready` pulses, read returns 0, and writes have no effect.
- **Async reset:** assert `resetn`=0 while `ready` is pending and the timer is running → all outputs go to 0 within the same cycle, and the counter is stopped after release.
